// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: one-to-four time-division demultiplexer.
// Collects four valid beats into one registered frame, with SYNC alignment.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   d           multiplexed data beat (W bits)
//   valid       d carries a beat this cycle
//   sync        with valid: beat is slot 0 of a frame
//   err_clr     clears sync_err (a same-cycle misalignment wins)
//   q           registered frame; lane i at q[W*i +: W]
//   frame_valid one-cycle pulse when q holds a new frame
//   slot        slot index the next valid beat will occupy
//   sync_err    sticky misalignment flag
//   frame_cnt   completed frames, modulo 256
module tdm_demux_1_4 #(
   parameter int W = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   d,
   input  logic           valid,
   input  logic           sync,
   input  logic           err_clr,
   output logic [4*W-1:0] q,
   output logic           frame_valid,
   output logic [1:0]     slot,
   output logic           sync_err,
   output logic [7:0]     frame_cnt
);

   logic [W-1:0] sh0;
   logic [W-1:0] sh1;
   logic [W-1:0] sh2;

   // Exactly one of these is set on a valid beat.
   logic misalign;
   logic complete;
   logic stash;

   always_comb begin
      misalign = 1'b0;
      complete = 1'b0;
      stash    = 1'b0;
      if (valid) begin
         misalign = sync && (slot != 2'd0);
         complete = !misalign && (slot == 2'd3);
         stash    = !misalign && (slot != 2'd3);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh0         <= '0;
         sh1         <= '0;
         sh2         <= '0;
         q           <= '0;
         slot        <= 2'd0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         frame_cnt   <= 8'd0;
      end else begin
         frame_valid <= 1'b0;
         if (err_clr) begin
            sync_err <= 1'b0;
         end
         if (valid) begin
            unique case (1'b1)
               misalign: begin
                  // Restart the frame at this beat; partial frame dropped.
                  sh0      <= d;
                  slot     <= 2'd1;
                  sync_err <= 1'b1;
               end
               complete: begin
                  q           <= {d, sh2, sh1, sh0};
                  slot        <= 2'd0;
                  frame_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + 8'd1;
               end
               stash: begin
                  unique case (slot)
                     2'd0:    sh0 <= d;
                     2'd1:    sh1 <= d;
                     default: sh2 <= d;
                  endcase
                  slot <= slot + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
